// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - operand forwarding select and load-use interlock scoreboard
// Optional feature macro HAZ_STATS_EN adds saturating stall/forward event counters.
module hazard_scoreboard #(
  parameter int RSIZE      = 4,
  parameter int NREG       = 16,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  localparam int SELW      = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_id_valid,
  input  logic [RSIZE-1:0] i_id_rs,
  input  logic [RSIZE-1:0] i_id_rt,
  input  logic             i_id_rs_used,
  input  logic             i_id_rt_used,
  input  logic [RSIZE-1:0] i_id_rd,
  input  logic             i_id_wen,
  input  logic             i_id_is_load,
  input  logic             i_flush,
  output logic             o_issue,
  output logic             o_stall,
  output logic [SELW-1:0]  o_fwd_rs_sel,
  output logic [SELW-1:0]  o_fwd_rt_sel,
  output logic [NREG-1:0]  o_busy_mask
`ifdef HAZ_STATS_EN
  ,
  output logic [15:0]      o_stat_stall_cnt,
  output logic [15:0]      o_stat_fwd_cnt
`endif
);

  // Index k-1 holds pipeline stage k (stage 1 = EX).
  logic [DEPTH-1:0] r_v;
  logic [DEPTH-1:0] r_ld;
  logic [RSIZE-1:0] r_rd [DEPTH];

  logic [SELW-1:0]  w_rs_k;
  logic [SELW-1:0]  w_rt_k;
  logic             w_rs_ld_haz;
  logic             w_rt_ld_haz;
  logic             w_stall;
  logic             w_issue;
  logic             w_alloc;
  logic [NREG-1:0]  w_busy;

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    w_rs_k      = '0;
    w_rt_k      = '0;
    w_rs_ld_haz = 1'b0;
    w_rt_ld_haz = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (r_v[k-1] && (r_rd[k-1] == i_id_rs) && (i_id_rs != '0) && i_id_rs_used) begin
        w_rs_k      = SELW'(k);
        w_rs_ld_haz = r_ld[k-1] && (k < LOAD_STAGE);
      end
      if (r_v[k-1] && (r_rd[k-1] == i_id_rt) && (i_id_rt != '0) && i_id_rt_used) begin
        w_rt_k      = SELW'(k);
        w_rt_ld_haz = r_ld[k-1] && (k < LOAD_STAGE);
      end
    end
  end

  assign w_stall = i_id_valid && !i_flush && (w_rs_ld_haz || w_rt_ld_haz);
  assign w_issue = i_id_valid && !w_stall && !i_flush;
  assign w_alloc = w_issue && i_id_wen && (i_id_rd != '0);

  always_comb begin
    w_busy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (r_v[k]) begin
        w_busy[r_rd[k]] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v <= '0;
    end else begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        r_v[k] <= r_v[k-1];
      end
      r_v[0] <= w_alloc;
    end
  end

  // Payload is qualified by r_v, so it needs no reset.
  always_ff @(posedge i_clk) begin
    for (int k = DEPTH - 1; k >= 1; k--) begin
      r_rd[k] <= r_rd[k-1];
      r_ld[k] <= r_ld[k-1];
    end
    r_rd[0] <= i_id_rd;
    r_ld[0] <= i_id_is_load;
  end

  assign o_issue      = w_issue;
  assign o_stall      = w_stall;
  assign o_fwd_rs_sel = i_id_valid ? w_rs_k : '0;
  assign o_fwd_rt_sel = i_id_valid ? w_rt_k : '0;
  assign o_busy_mask  = w_busy;

`ifdef HAZ_STATS_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_fwd_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (w_issue && ((w_rs_k != '0) || (w_rt_k != '0)) && (r_fwd_cnt != 16'hFFFF)) begin
        r_fwd_cnt <= r_fwd_cnt + 16'd1;
      end
    end
  end

  assign o_stat_stall_cnt = r_stall_cnt;
  assign o_stat_fwd_cnt   = r_fwd_cnt;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard
// Optional feature macro HAZ_STATS_EN also checks the statistics counters.
module tb_hazard_scoreboard;

  logic        clk;
  logic        i_rst;
  logic        i_id_valid;
  logic [3:0]  i_id_rs;
  logic [3:0]  i_id_rt;
  logic        i_id_rs_used;
  logic        i_id_rt_used;
  logic [3:0]  i_id_rd;
  logic        i_id_wen;
  logic        i_id_is_load;
  logic        i_flush;
  logic        o_issue;
  logic        o_stall;
  logic [1:0]  o_fwd_rs_sel;
  logic [1:0]  o_fwd_rt_sel;
  logic [15:0] o_busy_mask;
`ifdef HAZ_STATS_EN
  logic [15:0] o_stat_stall_cnt;
  logic [15:0] o_stat_fwd_cnt;
`endif

  hazard_scoreboard #(
    .RSIZE(4), .NREG(16), .DEPTH(3), .LOAD_STAGE(2)
  ) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_id_valid   (i_id_valid),
    .i_id_rs      (i_id_rs),
    .i_id_rt      (i_id_rt),
    .i_id_rs_used (i_id_rs_used),
    .i_id_rt_used (i_id_rt_used),
    .i_id_rd      (i_id_rd),
    .i_id_wen     (i_id_wen),
    .i_id_is_load (i_id_is_load),
    .i_flush      (i_flush),
    .o_issue      (o_issue),
    .o_stall      (o_stall),
    .o_fwd_rs_sel (o_fwd_rs_sel),
    .o_fwd_rt_sel (o_fwd_rt_sel),
    .o_busy_mask  (o_busy_mask)
`ifdef HAZ_STATS_EN
    ,
    .o_stat_stall_cnt (o_stat_stall_cnt),
    .o_stat_fwd_cnt   (o_stat_fwd_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       valid;
    logic [3:0] rs;
    logic       rsu;
    logic [3:0] rt;
    logic       rtu;
    logic [3:0] rd;
    logic       wen;
    logic       ld;
    logic       flush;
  } stim_t;

  // val = {stall, issue, rs_sel, rt_sel, busy_mask}
  typedef struct packed {
    logic [21:0] val;
    logic [21:0] care;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic stim_t mk_stim(input logic valid, input logic [3:0] rs, input logic rsu,
                                    input logic [3:0] rt, input logic rtu, input logic [3:0] rd,
                                    input logic wen, input logic ld, input logic flush,
                                    input logic rst);
    stim_t s;
    s = '{rst: rst, valid: valid, rs: rs, rsu: rsu, rt: rt, rtu: rtu,
          rd: rd, wen: wen, ld: ld, flush: flush};
    return s;
  endfunction

  // sel_dc marks cycles where the forwarding selects carry no meaning.
  function automatic exp_t mk_exp(input logic st, input logic is, input logic [1:0] rs,
                                  input logic [1:0] rt, input logic [15:0] busy,
                                  input logic sel_dc);
    exp_t e;
    e.val  = {st, is, rs, rt, busy};
    e.care = sel_dc ? 22'h30FFFF : 22'h3FFFFF;
    return e;
  endfunction

  function automatic logic [21:0] observed();
    return {o_stall, o_issue, o_fwd_rs_sel, o_fwd_rt_sel, o_busy_mask};
  endfunction

  task automatic drive(input stim_t s);
    i_rst        = s.rst;
    i_id_valid   = s.valid;
    i_id_rs      = s.rs;
    i_id_rs_used = s.rsu;
    i_id_rt      = s.rt;
    i_id_rt_used = s.rtu;
    i_id_rd      = s.rd;
    i_id_wen     = s.wen;
    i_id_is_load = s.ld;
    i_flush      = s.flush;
  endtask

  localparam stim_t IDLE = '0;

  task automatic test_reset();
    exp_t e;
    stim_t s;
    s = IDLE;
    s.rst = 1'b1;
    drive(s);
    repeat (2) @(posedge clk);
    #1;
    drive(IDLE);
    exp_q.push_back(mk_exp(0, 0, 0, 0, 16'h0000, 0));
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if ((observed() & e.care) !== (e.val & e.care))
      $display("FAIL reset: got %h expected %h", observed() & e.care, e.val & e.care);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_forward();
    stim_t s;
    exp_t  e;
    for (int i = 0; i < 5; i++) begin
      s = mk_stim(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
      case (i)
        0: begin s = mk_stim(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); e = mk_exp(0, 1, 0, 0, 16'h0000, 0); end
        1: e = mk_exp(0, 1, 1, 0, 16'h0008, 0);
        2: e = mk_exp(0, 1, 2, 0, 16'h0008, 0);
        3: e = mk_exp(0, 1, 3, 0, 16'h0008, 0);
        default: e = mk_exp(0, 1, 0, 0, 16'h0000, 0);
      endcase
      drive(s);
      exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ((observed() & e.care) !== (e.val & e.care))
        $display("FAIL forward[%0d]: got %h expected %h", i, observed() & e.care, e.val & e.care);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t s;
    exp_t  e;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin s = mk_stim(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); e = mk_exp(0, 1, 0, 0, 16'h0000, 0); end
        1: begin s = mk_stim(1, 0, 0, 5, 1, 0, 0, 0, 0, 0); e = mk_exp(1, 0, 0, 0, 16'h0020, 1); end
        2: begin s = mk_stim(1, 0, 0, 5, 1, 0, 0, 0, 0, 0); e = mk_exp(0, 1, 0, 2, 16'h0020, 0); end
        3: begin s = IDLE; e = mk_exp(0, 0, 0, 0, 16'h0020, 0); end
        default: begin s = IDLE; e = mk_exp(0, 0, 0, 0, 16'h0000, 0); end
      endcase
      drive(s);
      exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ((observed() & e.care) !== (e.val & e.care))
        $display("FAIL load_use[%0d]: got %h expected %h", i, observed() & e.care, e.val & e.care);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_youngest_and_r0();
    stim_t s;
    exp_t  e;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin s = mk_stim(1, 0, 0, 0, 0, 4, 1, 0, 0, 0); e = mk_exp(0, 1, 0, 0, 16'h0000, 0); end
        1: begin s = mk_stim(1, 0, 0, 0, 0, 4, 1, 0, 0, 0); e = mk_exp(0, 1, 0, 0, 16'h0010, 0); end
        2: begin s = mk_stim(1, 4, 1, 4, 1, 0, 0, 0, 0, 0); e = mk_exp(0, 1, 1, 1, 16'h0010, 0); end
        3: begin s = mk_stim(1, 0, 0, 0, 0, 0, 1, 0, 0, 0); e = mk_exp(0, 1, 0, 0, 16'h0010, 0); end
        4: begin s = mk_stim(1, 0, 1, 0, 1, 0, 0, 0, 0, 0); e = mk_exp(0, 1, 0, 0, 16'h0010, 0); end
        default: begin s = IDLE; e = mk_exp(0, 0, 0, 0, 16'h0000, 0); end
      endcase
      drive(s);
      exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ((observed() & e.care) !== (e.val & e.care))
        $display("FAIL youngest[%0d]: got %h expected %h", i, observed() & e.care, e.val & e.care);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    stim_t s;
    exp_t  e;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin s = mk_stim(1, 0, 0, 0, 0, 6, 1, 1, 0, 0); e = mk_exp(0, 1, 0, 0, 16'h0000, 0); end
        // The flushed instruction also writes r7: it must not reach the scoreboard.
        1: begin s = mk_stim(1, 6, 1, 0, 0, 7, 1, 0, 1, 0); e = mk_exp(0, 0, 0, 0, 16'h0040, 1); end
        2: begin s = mk_stim(1, 6, 1, 0, 0, 0, 0, 0, 0, 0); e = mk_exp(0, 1, 2, 0, 16'h0040, 0); end
        3: begin s = IDLE; e = mk_exp(0, 0, 0, 0, 16'h0040, 0); end
        default: begin s = IDLE; e = mk_exp(0, 0, 0, 0, 16'h0000, 0); end
      endcase
      drive(s);
      exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ((observed() & e.care) !== (e.val & e.care))
        $display("FAIL flush[%0d]: got %h expected %h", i, observed() & e.care, e.val & e.care);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_stall();
    stim_t s;
    exp_t  e;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin s = mk_stim(1, 0, 0, 0, 0, 9, 1, 1, 0, 0); e = mk_exp(0, 1, 0, 0, 16'h0000, 0); end
        1: begin s = mk_stim(1, 9, 1, 0, 0, 0, 0, 0, 0, 1); e = mk_exp(1, 0, 0, 0, 16'h0200, 1); end
        default: begin s = mk_stim(1, 9, 1, 0, 0, 0, 0, 0, 0, 0); e = mk_exp(0, 1, 0, 0, 16'h0000, 0); end
      endcase
      drive(s);
      exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ((observed() & e.care) !== (e.val & e.care))
        $display("FAIL rst_stall[%0d]: got %h expected %h", i, observed() & e.care, e.val & e.care);
      else n_pass++;
`ifdef HAZ_STATS_EN
      if (i == 2) begin
        n_checks++;
        if (o_stat_stall_cnt !== 16'h0000)
          $display("FAIL stat_stall_cnt: got %h expected 0000", o_stat_stall_cnt);
        else n_pass++;
      end
`endif
      @(posedge clk); #1;
    end
    drive(IDLE);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    drive(IDLE);
    test_reset();
    test_forward();
    test_load_use();
    test_youngest_and_r0();
    test_flush();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
